// File: rtl/hazard_scoreboard_unit.sv
// Hazard-detection and forwarding unit. It tracks in-flight destinations in a
// shift-register scoreboard and derives bypass selects, load-use stalls and pipeline enables.
module hazard_scoreboard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 0,   // legal range 0..DEPTH-2
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic                       id_rf_enable,
    input  logic                       id_load,
    input  logic                       flush,
    input  logic                       hold,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic                       pc_le,
    output logic                       ifid_le,
    output logic                       ctrl_nop,
    output logic [CNT_W-1:0]           stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              rf_en;
        logic              load;
    } entry_t;

    // Entry 0 is EX, entry 1 is MEM, entry 2 is WB, and so on.
    entry_t [DEPTH-1:0] sb_q, sb_d;
    logic   [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               load_hit;

    // For each operand, search from the youngest entry. The first match is the bypass source.
    always_comb begin : match_logic
        logic [REG_AW-1:0] src;
        logic              found;
        // NOTE: each variable gets a default at the top of the block. Without it, a
        // path that skips the assignment would infer a latch.
        fwd_sel  = '0;
        load_hit = 1'b0;
        src      = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src   = id_src[i*REG_AW +: REG_AW];
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && id_src_used[i] && (src != '0) &&
                    sb_q[k].valid && sb_q[k].rf_en && (sb_q[k].rd == src)) begin
                    found                       = 1'b1;
                    fwd_sel[i*SEL_W +: SEL_W]   = SEL_W'(k + 1);
                    if (sb_q[k].load && (k <= LOAD_LAT)) begin
                        load_hit = 1'b1;
                    end
                end
            end
        end
    end

    // A squashed ID instruction never stalls.
    assign stall    = id_valid & ~flush & load_hit;
    assign pc_le    = ~(stall | hold);
    assign ifid_le  = ~(stall | hold);
    assign ctrl_nop = stall & ~hold;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb_d[k] = sb_q[k - 1];
            end
            if (id_valid && !flush && !stall) begin
                sb_d[0] = '{valid: 1'b1, rd: id_rd, rf_en: id_rf_enable, load: id_load};
            end else begin
                sb_d[0] = '0;
            end
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops sample
    // together, so the order in which they update does not matter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit. It runs one default instance (LOAD_LAT=0)
// and one LOAD_LAT=1 instance with a 2-bit counter, so that saturation is reachable.
module tb_hazard_scoreboard_unit;

    logic clk;
    logic reset;

    logic        valid0, rfe0, ld0, flush0, hold0;
    logic [9:0]  src0;
    logic [1:0]  used0;
    logic [4:0]  rd0;
    logic [3:0]  fwd0;
    logic        stall0, pcle0, ifidle0, nop0;
    logic [15:0] cnt0;

    logic        valid1, rfe1, ld1, flush1, hold1;
    logic [9:0]  src1;
    logic [1:0]  used1;
    logic [4:0]  rd1;
    logic [3:0]  fwd1;
    logic        stall1, pcle1, ifidle1, nop1;
    logic [1:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard_unit dut0 (
        .clk(clk), .reset(reset), .id_valid(valid0), .id_src(src0),
        .id_src_used(used0), .id_rd(rd0), .id_rf_enable(rfe0), .id_load(ld0),
        .flush(flush0), .hold(hold0), .fwd_sel(fwd0), .stall(stall0),
        .pc_le(pcle0), .ifid_le(ifidle0), .ctrl_nop(nop0), .stall_cnt(cnt0)
    );

    hazard_scoreboard_unit #(.LOAD_LAT(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .id_valid(valid1), .id_src(src1),
        .id_src_used(used1), .id_rd(rd1), .id_rf_enable(rfe1), .id_load(ld1),
        .flush(flush1), .hold(hold1), .fwd_sel(fwd1), .stall(stall1),
        .pc_le(pcle1), .ifid_le(ifidle1), .ctrl_nop(nop1), .stall_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] rd, input logic rfe, input logic ld);
        valid0 = v; src0 = {s1, s0}; used0 = used; rd0 = rd; rfe0 = rfe; ld0 = ld;
        #1;
    endtask

    task automatic drv1(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] rd, input logic rfe, input logic ld);
        valid1 = v; src1 = {s1, s0}; used1 = used; rd1 = rd; rfe1 = rfe; ld1 = ld;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        flush0 = 1'b0; hold0 = 1'b0; flush1 = 1'b0; hold1 = 1'b0;
        drv0(1'b1, 5'd5, 5'd4, 2'b11, 5'd5, 1'b1, 1'b1);
        drv1(1'b1, 5'd4, 5'd5, 2'b11, 5'd4, 1'b1, 1'b1);

        // Reset with live-looking ID inputs: nothing may match cleared entries.
        tick(); tick();
        check("rst_fwd0", fwd0, 4'h0);
        check("rst_stall0", stall0, 1'b0);
        check("rst_pcle0", pcle0, 1'b1);
        check("rst_ifidle0", ifidle0, 1'b1);
        check("rst_nop0", nop0, 1'b0);
        check("rst_cnt0", cnt0, 16'd0);
        check("rst_fwd1", fwd1, 4'h0);
        check("rst_cnt1", cnt1, 2'd0);

        drv0(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        drv1(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();

        // ALU chain: addiu $5. Then readers of $5 see EX, MEM, WB and finally the register file.
        drv0(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);
        tick();
        drv0(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        check("alu_ex", fwd0, 4'h1);
        check("alu_ex_stall", stall0, 1'b0);
        tick();
        check("alu_mem", fwd0, 4'h2);
        tick();
        check("alu_wb", fwd0, 4'h3);
        tick();
        check("alu_rf", fwd0, 4'h0);

        // Load-use with LOAD_LAT=0: lbu $4, then the reader uses rt=$4.
        drv0(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1);
        tick();
        drv0(1'b1, 5'd0, 5'd4, 2'b10, 5'd6, 1'b1, 1'b0);
        check("lu0_stall", stall0, 1'b1);
        check("lu0_pcle", pcle0, 1'b0);
        check("lu0_ifidle", ifidle0, 1'b0);
        check("lu0_nop", nop0, 1'b1);
        tick();
        check("lu0_stall_end", stall0, 1'b0);
        check("lu0_fwd", fwd0, 4'h8);
        check("lu0_pcle_end", pcle0, 1'b1);
        check("lu0_cnt", cnt0, 16'd1);

        // Two writers of $7: the youngest wins. A $0 writer is never forwarded.
        drv0(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);
        tick();
        tick();
        drv0(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        check("young_7", fwd0, 4'h1);
        drv0(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
        tick();
        drv0(1'b1, 5'd7, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
        check("r0_and_7", fwd0, 4'h2);
        check("r0_stall", stall0, 1'b0);

        // Flush: the load-use is squashed, and a bubble enters EX in place of the reader.
        drv0(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1);
        tick();
        flush0 = 1'b1;
        drv0(1'b1, 5'd8, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        check("flush_stall", stall0, 1'b0);
        check("flush_nop", nop0, 1'b0);
        check("flush_pcle", pcle0, 1'b1);
        tick();
        flush0 = 1'b0;
        #1;
        check("flush_bubble", fwd0, 4'h2);
        check("flush_cnt", cnt0, 16'd1);

        // Hold freezes the entries and the counter while a load-use is pending.
        drv0(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
        tick();
        hold0 = 1'b1;
        drv0(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0);
        check("hold_stall", stall0, 1'b1);
        check("hold_pcle", pcle0, 1'b0);
        check("hold_ifidle", ifidle0, 1'b0);
        check("hold_nop", nop0, 1'b0);
        tick(); tick(); tick();
        check("hold_cnt", cnt0, 16'd1);
        check("hold_fwd", fwd0, 4'h1);
        check("hold_stall3", stall0, 1'b1);
        hold0 = 1'b0;
        #1;
        check("unhold_nop", nop0, 1'b1);
        tick();
        check("unhold_cnt", cnt0, 16'd2);
        check("unhold_stall", stall0, 1'b0);
        check("unhold_fwd", fwd0, 4'h2);
        drv0(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);

        // LOAD_LAT=1: a load in EX gives 2 bubbles, and the reader then forwards from WB.
        drv1(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1);
        tick();
        drv1(1'b1, 5'd0, 5'd4, 2'b10, 5'd6, 1'b1, 1'b0);
        check("lu1_stall_a", stall1, 1'b1);
        tick();
        check("lu1_stall_b", stall1, 1'b1);
        check("lu1_nop_b", nop1, 1'b1);
        tick();
        check("lu1_stall_end", stall1, 1'b0);
        check("lu1_fwd", fwd1, 4'hC);
        check("lu1_cnt", cnt1, 2'd2);

        // LOAD_LAT=1: a load already in MEM gives 1 bubble.
        drv1(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1);
        tick();
        drv1(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0);
        tick();
        drv1(1'b1, 5'd3, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0);
        check("mem_stall", stall1, 1'b1);
        tick();
        check("mem_stall_end", stall1, 1'b0);
        check("mem_fwd", fwd1, 4'h3);
        check("mem_cnt", cnt1, 2'd3);

        // Further stalls must keep the 2-bit counter at its maximum.
        drv1(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1);
        tick();
        drv1(1'b1, 5'd0, 5'd4, 2'b10, 5'd6, 1'b1, 1'b0);
        check("sat_stall", stall1, 1'b1);
        tick();
        check("sat_cnt_a", cnt1, 2'd3);
        tick();
        check("sat_cnt_b", cnt1, 2'd3);
        check("sat_fwd", fwd1, 4'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
